// File: rtl/pipe_trace_monitor.sv
// Event counters and retire-trace FIFO tapping a 5-stage pipeline's WB, hazard and forwarding signals.
// Define TRACE_RD_FILTER_EN to trace only register-writing instructions with rd != x0.
module pipe_trace_monitor #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned TRACE_DEPTH = 16,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         clear,
  input  logic                         stall,
  input  logic                         branch_taken,
  input  logic [1:0]                   forward_a,
  input  logic [1:0]                   forward_b,
  input  logic                         wb_valid,
  input  logic                         wb_regwrite,
  input  logic [4:0]                   wb_rd,
  input  logic [XLEN-1:0]              wb_pc,
  input  logic [XLEN-1:0]              wb_data,
  input  logic [2:0]                   cnt_sel,
  output logic [CNT_WIDTH-1:0]         cnt_out,
  output logic                         trc_valid,
  input  logic                         trc_ready,
  output logic [XLEN-1:0]              trc_pc,
  output logic [4:0]                   trc_rd,
  output logic [XLEN-1:0]              trc_data,
  output logic [$clog2(TRACE_DEPTH):0] trc_count,
  output logic                         trc_overflow
);

  localparam int unsigned AW   = $clog2(TRACE_DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned NCNT = 7;
  localparam int unsigned C_CYCLES  = 0;
  localparam int unsigned C_RETIRED = 1;
  localparam int unsigned C_STALLS  = 2;
  localparam int unsigned C_FLUSHES = 3;
  localparam int unsigned C_EXMEM   = 4;
  localparam int unsigned C_MEMWB   = 5;
  localparam int unsigned C_DROPPED = 6;

  logic [CNT_WIDTH-1:0] r_cnt [NCNT];
  logic [1:0]           w_inc [NCNT];

  logic [XLEN-1:0] r_mem_pc   [TRACE_DEPTH];
  logic [4:0]      r_mem_rd   [TRACE_DEPTH];
  logic [XLEN-1:0] r_mem_data [TRACE_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;

  logic w_empty;
  logic w_full;
  logic w_push_req;
  logic w_push;
  logic w_pop;
  logic w_drop;

  assign w_empty = (r_count == CW'(0));
  assign w_full  = (r_count == CW'(TRACE_DEPTH));

`ifdef TRACE_RD_FILTER_EN
  assign w_push_req = !clear && enable && wb_valid && wb_regwrite && (wb_rd != 5'd0);
`else
  logic w_unused_regwrite;
  assign w_unused_regwrite = wb_regwrite;
  assign w_push_req = !clear && enable && wb_valid;
`endif

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_pop  = !clear && !w_empty && trc_ready;
  assign w_push = w_push_req && (!w_full || w_pop);
  assign w_drop = w_push_req && w_full && !w_pop;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [1:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {{(CNT_WIDTH - 1) {1'b0}}, b};
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < NCNT; i++) w_inc[i] = 2'd0;
    w_inc[C_CYCLES]  = 2'd1;
    w_inc[C_RETIRED] = {1'b0, wb_valid};
    w_inc[C_STALLS]  = {1'b0, stall};
    w_inc[C_FLUSHES] = {1'b0, branch_taken};
    w_inc[C_EXMEM]   = {1'b0, forward_a == 2'b10} + {1'b0, forward_b == 2'b10};
    w_inc[C_MEMWB]   = {1'b0, forward_a == 2'b01} + {1'b0, forward_b == 2'b01};
    w_inc[C_DROPPED] = {1'b0, w_drop};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCNT; i++) r_cnt[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NCNT; i++) r_cnt[i] <= '0;
    end else if (enable) begin
      for (int i = 0; i < NCNT; i++) r_cnt[i] <= sat_add(r_cnt[i], w_inc[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Storage needs no reset; reads are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wptr]   <= wb_pc;
      r_mem_rd[r_wptr]   <= wb_rd;
      r_mem_data[r_wptr] <= wb_data;
    end
  end

  always_comb begin
    cnt_out = '0;
    case (cnt_sel)
      3'd0:    cnt_out = r_cnt[C_CYCLES];
      3'd1:    cnt_out = r_cnt[C_RETIRED];
      3'd2:    cnt_out = r_cnt[C_STALLS];
      3'd3:    cnt_out = r_cnt[C_FLUSHES];
      3'd4:    cnt_out = r_cnt[C_EXMEM];
      3'd5:    cnt_out = r_cnt[C_MEMWB];
      3'd6:    cnt_out = r_cnt[C_DROPPED];
      default: cnt_out = '0;
    endcase
  end

  assign trc_valid    = !w_empty;
  assign trc_pc       = w_empty ? '0 : r_mem_pc[r_rptr];
  assign trc_rd       = w_empty ? '0 : r_mem_rd[r_rptr];
  assign trc_data     = w_empty ? '0 : r_mem_data[r_rptr];
  assign trc_count    = r_count;
  assign trc_overflow = r_overflow;

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// Bench for pipe_trace_monitor: a queue/integer model checked every cycle plus literal spot checks.
module tb_pipe_trace_monitor;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 16;

  logic            clk, reset, enable, clear, stall, branch_taken;
  logic [1:0]      forward_a, forward_b;
  logic            wb_valid, wb_regwrite;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_pc, wb_data;
  logic [2:0]      cnt_sel;
  logic            trc_ready;

  logic [31:0]     cnt_out;
  logic            trc_valid, trc_overflow;
  logic [XLEN-1:0] trc_pc, trc_data;
  logic [4:0]      trc_rd;
  logic [4:0]      trc_count;

  logic [3:0]      s_cnt_out;
  logic            s_trc_valid, s_trc_overflow;
  logic [XLEN-1:0] s_trc_pc, s_trc_data;
  logic [4:0]      s_trc_rd;
  logic [4:0]      s_trc_count;

  pipe_trace_monitor #(.XLEN(XLEN), .TRACE_DEPTH(DEPTH), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .stall(stall),
    .branch_taken(branch_taken), .forward_a(forward_a), .forward_b(forward_b),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_pc(wb_pc),
    .wb_data(wb_data), .cnt_sel(cnt_sel), .cnt_out(cnt_out), .trc_valid(trc_valid),
    .trc_ready(trc_ready), .trc_pc(trc_pc), .trc_rd(trc_rd), .trc_data(trc_data),
    .trc_count(trc_count), .trc_overflow(trc_overflow));

  // Narrow-counter instance sharing the stimulus, to exercise saturation.
  pipe_trace_monitor #(.XLEN(XLEN), .TRACE_DEPTH(DEPTH), .CNT_WIDTH(4)) dut_s (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .stall(stall),
    .branch_taken(branch_taken), .forward_a(forward_a), .forward_b(forward_b),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_pc(wb_pc),
    .wb_data(wb_data), .cnt_sel(cnt_sel), .cnt_out(s_cnt_out), .trc_valid(s_trc_valid),
    .trc_ready(trc_ready), .trc_pc(s_trc_pc), .trc_rd(s_trc_rd), .trc_data(s_trc_data),
    .trc_count(s_trc_count), .trc_overflow(s_trc_overflow));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int rot    = 0;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t              q[$];
  longint unsigned   m_cnt[7];
  logic              m_ovf;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_cnt(input int sel, input int w);
    longint unsigned mx;
    if (sel >= 7) return 64'd0;
    mx = (64'd1 << w) - 64'd1;
    return (m_cnt[sel] > mx) ? mx : m_cnt[sel];
  endfunction

  task automatic m_reset();
    q.delete();
    for (int i = 0; i < 7; i++) m_cnt[i] = 0;
    m_ovf = 1'b0;
  endtask

  // Next state from the current inputs, applied as if at the coming rising edge.
  task automatic m_step();
    bit pop, pushreq;
    ent_t e;
    if (clear) begin
      m_reset();
      return;
    end
    pop = (q.size() != 0) && trc_ready;
`ifdef TRACE_RD_FILTER_EN
    pushreq = enable && wb_valid && wb_regwrite && (wb_rd != 5'd0);
`else
    pushreq = enable && wb_valid;
`endif
    if (enable) begin
      m_cnt[0] += 1;
      m_cnt[1] += longint'(wb_valid);
      m_cnt[2] += longint'(stall);
      m_cnt[3] += longint'(branch_taken);
      m_cnt[4] += longint'(forward_a == 2'b10) + longint'(forward_b == 2'b10);
      m_cnt[5] += longint'(forward_a == 2'b01) + longint'(forward_b == 2'b01);
    end
    if (pop) void'(q.pop_front());
    if (pushreq) begin
      if (q.size() < DEPTH) begin
        e.pc = wb_pc; e.rd = wb_rd; e.data = wb_data;
        q.push_back(e);
      end else begin
        m_cnt[6] += 1;
        m_ovf = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    logic [63:0] epc, edata;
    logic [4:0]  erd;
    if (!reset) m_reset();
    epc   = (q.size() != 0) ? q[0].pc : 64'd0;
    erd   = (q.size() != 0) ? q[0].rd : 5'd0;
    edata = (q.size() != 0) ? q[0].data : 64'd0;
    check("trc_valid", 64'(trc_valid), 64'(q.size() != 0));
    check("trc_count", 64'(trc_count), 64'(q.size()));
    check("trc_pc", trc_pc, epc);
    check("trc_rd", 64'(trc_rd), 64'(erd));
    check("trc_data", trc_data, edata);
    check("trc_overflow", 64'(trc_overflow), 64'(m_ovf));
    check("cnt_out", 64'(cnt_out), exp_cnt(int'(cnt_sel), 32));
    check("cnt_out_w4", 64'(s_cnt_out), exp_cnt(int'(cnt_sel), 4));
    check("w4_trc_count", 64'(s_trc_count), 64'(q.size()));
    check("w4_trc_pc", s_trc_pc, epc);
    check("w4_trc_overflow", 64'(s_trc_overflow), 64'(m_ovf));
    if (reset) m_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cnt_sel = 3'(rot % 8);
    rot++;
  endtask

  task automatic set_wb(input logic [63:0] pc, input logic [4:0] rd, input logic rw);
    wb_pc       = pc;
    wb_rd       = rd;
    wb_regwrite = rw;
    wb_data     = {32'hDA7A_0000 ^ pc[31:0], ~pc[31:0]};
  endtask

  task automatic chk_cnt(input string name, input logic [2:0] sel, input logic [63:0] exp);
    cnt_sel = sel;
    #1;
    check(name, 64'(cnt_out), exp);
  endtask

  task automatic chk_cnt_s(input string name, input logic [2:0] sel, input logic [63:0] exp);
    cnt_sel = sel;
    #1;
    check(name, 64'(s_cnt_out), exp);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; clear = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    forward_a = 2'b00; forward_b = 2'b00; wb_valid = 1'b0; trc_ready = 1'b0;
    cnt_sel = 3'd0;
    set_wb(64'd0, 5'd0, 1'b0);
    tick(); tick();
    check("reset_valid", 64'(trc_valid), 64'd0);
    chk_cnt("reset_cycles", 3'd0, 64'd0);
    reset = 1'b1;
    tick();

    // Ten enabled cycles, three of them stalled.
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      stall = (i == 2 || i == 5 || i == 7);
      branch_taken = (i == 4);
      tick();
    end
    enable = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    chk_cnt("cycles10", 3'd0, 64'd10);
    chk_cnt("stalls3", 3'd2, 64'd3);
    chk_cnt("flushes1", 3'd3, 64'd1);
    check("valid_idle", 64'(trc_valid), 64'd0);

    // Forwarding: both EX/MEM, then MEM/WB plus the 2'b11 alias of none.
    enable = 1'b1; forward_a = 2'b10; forward_b = 2'b10;
    tick();
    forward_a = 2'b01; forward_b = 2'b11;
    tick();
    enable = 1'b0; forward_a = 2'b00; forward_b = 2'b00;
    chk_cnt("fwd_exmem2", 3'd4, 64'd2);
    chk_cnt("fwd_memwb1", 3'd5, 64'd1);

    // Fill past capacity with the host stalled.
    enable = 1'b1; wb_valid = 1'b1; trc_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      set_wb(64'(4 * i), 5'((i % 31) + 1), 1'b1);
      tick();
    end
    wb_valid = 1'b0; enable = 1'b0;
    check("full_count", 64'(trc_count), 64'd16);
    check("full_ovf", 64'(trc_overflow), 64'd1);
    check("full_head", trc_pc, 64'h0);
    chk_cnt("dropped2", 3'd6, 64'd2);

    // Full FIFO with simultaneous push and pop.
    enable = 1'b1; wb_valid = 1'b1; trc_ready = 1'b1;
    set_wb(64'h100, 5'd9, 1'b1);
    tick();
    enable = 1'b0; wb_valid = 1'b0; trc_ready = 1'b0;
    check("pp_count", 64'(trc_count), 64'd16);
    check("pp_head", trc_pc, 64'h4);
    chk_cnt("pp_dropped", 3'd6, 64'd2);

    // Drain with capture stopped; order must be 0x4..0x3C then 0x100.
    trc_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("drain_pc", trc_pc, (k < 15) ? 64'(4 * (k + 1)) : 64'h100);
      tick();
    end
    check("drained_valid", 64'(trc_valid), 64'd0);
    check("drained_ovf", 64'(trc_overflow), 64'd1);

    // Empty FIFO with push and pop together: push wins, pop ignored.
    enable = 1'b1; wb_valid = 1'b1;
    set_wb(64'h200, 5'd3, 1'b1);
    tick();
    check("empty_pp_count", 64'(trc_count), 64'd1);
    check("empty_pp_pc", trc_pc, 64'h200);
    enable = 1'b0; wb_valid = 1'b0;
    tick();
    check("empty_pp_drain", 64'(trc_count), 64'd0);

    // Asynchronous reset while entries are pending.
    trc_ready = 1'b0; enable = 1'b1; wb_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_wb(64'h300 + 64'(4 * i), 5'd7, 1'b1);
      tick();
    end
    enable = 1'b0; wb_valid = 1'b0;
    check("pre_rst_count", 64'(trc_count), 64'd3);
    trc_ready = 1'b1;
    #2 reset = 1'b0;
    #1 check("async_rst_valid", 64'(trc_valid), 64'd0);
    check("async_rst_count", 64'(trc_count), 64'd0);
    tick();
    reset = 1'b1;
    tick();

    // Counter saturation on the 4-bit instance.
    enable = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    enable = 1'b0;
    chk_cnt("cycles20", 3'd0, 64'd20);
    chk_cnt_s("sat_cycles", 3'd0, 64'hF);
    chk_cnt("sel7_zero", 3'd7, 64'd0);

    // Overflow, then clear with a push presented in the same cycle.
    enable = 1'b1; wb_valid = 1'b1; trc_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      set_wb(64'h400 + 64'(4 * i), 5'd2, 1'b1);
      tick();
    end
    check("pre_clr_ovf", 64'(trc_overflow), 64'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0; enable = 1'b0; wb_valid = 1'b0;
    check("clr_count", 64'(trc_count), 64'd0);
    check("clr_ovf", 64'(trc_overflow), 64'd0);
    chk_cnt("clr_cycles", 3'd0, 64'd0);
    chk_cnt_s("clr_cycles_w4", 3'd0, 64'd0);
    chk_cnt("clr_dropped", 3'd6, 64'd0);

    // Retire rd=0, rd=5, and a non-writing instruction.
    enable = 1'b1; wb_valid = 1'b1;
    set_wb(64'h500, 5'd0, 1'b1); tick();
    set_wb(64'h504, 5'd5, 1'b1); tick();
    set_wb(64'h508, 5'd7, 1'b0); tick();
    enable = 1'b0; wb_valid = 1'b0;
    chk_cnt("flt_retired", 3'd1, 64'd3);
    chk_cnt("flt_dropped", 3'd6, 64'd0);
`ifdef TRACE_RD_FILTER_EN
    check("flt_count", 64'(trc_count), 64'd1);
    check("flt_rd", 64'(trc_rd), 64'd5);
`else
    check("flt_count", 64'(trc_count), 64'd3);
    check("flt_rd", 64'(trc_rd), 64'd0);
`endif
    trc_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
